// File: rtl/status_blink_scheduler.sv
// Round-robin scheduler that plays per-requester blink counts on one shared indicator.
// Each grant produces N pulses, then an inter-code gap, then a one-cycle ack.
module status_blink_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int CODE_W     = 3,
    parameter int ON_CYCLES  = 20,
    parameter int OFF_CYCLES = 20,
    parameter int GAP_CYCLES = 80
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*CODE_W-1:0]  code,
    output logic                       led_out,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         ack,
    output logic                       busy
);

    localparam int MAX_ON_OFF = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int MAX_CYC    = (MAX_ON_OFF > GAP_CYCLES) ? MAX_ON_OFF : GAP_CYCLES;
    localparam int TIMER_W    = $clog2(MAX_CYC) + 1;
    localparam int IDX_W      = $clog2(NUM_REQ);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ON   = 2'd1;
    localparam logic [1:0] S_OFF  = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    localparam logic [TIMER_W-1:0] ON_LAST  = TIMER_W'(ON_CYCLES - 1);
    localparam logic [TIMER_W-1:0] OFF_LAST = TIMER_W'(OFF_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_LAST = TIMER_W'(GAP_CYCLES - 1);

    logic [1:0]         r_state;
    logic [TIMER_W-1:0] r_timer;
    logic [CODE_W-1:0]  r_pulses;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   r_last;
    logic               r_led;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] r_ack;
    logic               r_busy;

    logic [NUM_REQ-1:0] w_eligible;
    logic               w_found;
    logic [IDX_W-1:0]   w_sel;
    logic [IDX_W:0]     w_rr_idx;
    logic [CODE_W-1:0]  w_sel_code;

    // A requester with a zero count is never eligible, so it is never granted or acked.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_eligible[i] = req[i] && (code[i*CODE_W +: CODE_W] != '0);
        end
    end

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_found  = 1'b0;
        w_sel    = '0;
        w_rr_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_rr_idx = {1'b0, r_last} + (IDX_W+1)'(k) + (IDX_W+1)'(1);
            if (w_rr_idx >= (IDX_W+1)'(NUM_REQ)) begin
                w_rr_idx = w_rr_idx - (IDX_W+1)'(NUM_REQ);
            end
            if (!w_found && w_eligible[w_rr_idx[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_rr_idx[IDX_W-1:0];
            end
        end
    end

    assign w_sel_code = code[w_sel*CODE_W +: CODE_W];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_timer  <= '0;
            r_pulses <= '0;
            r_idx    <= '0;
            r_last   <= IDX_W'(NUM_REQ - 1);
            r_led    <= 1'b0;
            r_grant  <= '0;
            r_ack    <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_ack <= '0;
            case (r_state)
                S_IDLE: begin
                    if (enable && w_found) begin
                        r_state  <= S_ON;
                        r_timer  <= '0;
                        r_pulses <= w_sel_code;
                        r_idx    <= w_sel;
                        r_last   <= w_sel;
                        r_led    <= 1'b1;
                        r_grant  <= NUM_REQ'(1) << w_sel;
                        r_busy   <= 1'b1;
                    end
                end
                S_ON: begin
                    if (r_timer == ON_LAST) begin
                        r_timer  <= '0;
                        r_pulses <= r_pulses - CODE_W'(1);
                        r_led    <= 1'b0;
                        // Last pulse of the code heads to the gap instead of the inter-pulse low.
                        r_state  <= (r_pulses != CODE_W'(1)) ? S_OFF : S_GAP;
                    end else begin
                        r_timer <= r_timer + TIMER_W'(1);
                    end
                end
                S_OFF: begin
                    if (r_timer == OFF_LAST) begin
                        r_timer <= '0;
                        r_led   <= 1'b1;
                        r_state <= S_ON;
                    end else begin
                        r_timer <= r_timer + TIMER_W'(1);
                    end
                end
                S_GAP: begin
                    if (r_timer == GAP_LAST) begin
                        r_timer <= '0;
                        r_state <= S_IDLE;
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_ack   <= NUM_REQ'(1) << r_idx;
                    end else begin
                        r_timer <= r_timer + TIMER_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign led_out = r_led;
    assign grant   = r_grant;
    assign ack     = r_ack;
    assign busy    = r_busy;

endmodule

// File: tb/tb_status_blink_scheduler.sv
// Directed bench for status_blink_scheduler with short ON/OFF/GAP timing.
// Outputs are sampled on the falling edge; inputs also change on the falling edge.
module tb_status_blink_scheduler;

    localparam int NUM_REQ = 4;
    localparam int CODE_W  = 3;

    logic                      clk;
    logic                      rst;
    logic                      enable;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*CODE_W-1:0] code;
    logic                      led_out;
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ-1:0]        ack;
    logic                      busy;

    int n_checks;
    int n_fail;

    status_blink_scheduler #(
        .NUM_REQ    (NUM_REQ),
        .CODE_W     (CODE_W),
        .ON_CYCLES  (2),
        .OFF_CYCLES (3),
        .GAP_CYCLES (5)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .req     (req),
        .code    (code),
        .led_out (led_out),
        .grant   (grant),
        .ack     (ack),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [16:0] pat;
        logic [3:0]  rot [6];
        int          rises;
        int          nbusy;
        int          nack;
        logic        prev_led;

        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        enable   = 1'b0;
        req      = '0;
        code     = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_led",   32'(led_out), 32'd0);
        check("rst_grant", 32'(grant),   32'd0);
        check("rst_ack",   32'(ack),     32'd0);
        check("rst_busy",  32'(busy),    32'd0);
        rst    = 1'b0;
        enable = 1'b1;
        step();

        // Requester 1 with code 3: 2 on/3 off/2 on/3 off/2 on/5 gap
        pat  = 17'b11000110001100000;
        req  = 4'b0010;
        code = 12'b000_000_011_000;
        step();
        req = 4'b0000;
        for (int k = 0; k < 17; k++) begin
            check("c3_led",   32'(led_out), 32'(pat[16-k]));
            check("c3_busy",  32'(busy),    32'd1);
            check("c3_grant", 32'(grant),   32'b0010);
            step();
        end
        check("c3_ack",       32'(ack),     32'b0010);
        check("c3_ack_busy",  32'(busy),    32'd0);
        check("c3_ack_grant", 32'(grant),   32'd0);
        check("c3_ack_led",   32'(led_out), 32'd0);
        step();
        check("c3_ack_once",  32'(ack),     32'd0);

        // Rotation across requesters 0, 2, 3 with code 1, starting fresh from reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        rot = '{4'b0001, 4'b0100, 4'b1000, 4'b0001, 4'b0100, 4'b1000};
        req  = 4'b1101;
        code = 12'b001_001_000_001;
        step();
        for (int i = 0; i < 6; i++) begin
            check("rr_grant",     32'(grant),   32'(rot[i]));
            check("rr_led",       32'(led_out), 32'd1);
            repeat (6) step();
            check("rr_last_busy", 32'(busy),    32'd1);
            check("rr_last_gnt",  32'(grant),   32'(rot[i]));
            step();
            check("rr_ack",       32'(ack),     32'(rot[i]));
            check("rr_ack_busy",  32'(busy),    32'd0);
            check("rr_ack_grant", 32'(grant),   32'd0);
            if (i == 5) req = 4'b0000;
            step();
        end

        // Code-0 requester 2 is skipped; requester 3 (code 2) is played alone
        req  = 4'b1100;
        code = 12'b010_000_000_000;
        step();
        req = 4'b0100;
        for (int k = 0; k < 12; k++) begin
            check("z_grant", 32'(grant), 32'b1000);
            check("z_busy",  32'(busy),  32'd1);
            step();
        end
        check("z_ack",      32'(ack),  32'b1000);
        check("z_ack_busy", 32'(busy), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("z_idle_grant", 32'(grant), 32'd0);
            check("z_idle_busy",  32'(busy),  32'd0);
            check("z_idle_ack",   32'(ack),   32'd0);
        end
        req = 4'b0000;

        // Code 4 latched; code and req changed during playback
        req  = 4'b0001;
        code = 12'b000_000_000_100;
        step();
        check("lat_grant", 32'(grant), 32'b0001);
        code     = 12'b000_000_000_111;
        req      = 4'b0000;
        rises    = 0;
        nbusy    = 0;
        nack     = 0;
        prev_led = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (led_out && !prev_led) rises++;
            prev_led = led_out;
            if (busy) nbusy++;
            if (ack[0]) nack++;
            step();
        end
        check("lat_pulses", 32'(rises), 32'd4);
        check("lat_busy",   32'(nbusy), 32'd22);
        check("lat_acks",   32'(nack),  32'd1);

        // enable dropped mid-code with requester 2 pending
        req  = 4'b0110;
        code = 12'b000_001_001_000;
        step();
        check("en_grant", 32'(grant), 32'b0010);
        req = 4'b0100;
        repeat (2) step();
        enable = 1'b0;
        repeat (5) step();
        check("en_ack",      32'(ack),  32'b0010);
        check("en_ack_busy", 32'(busy), 32'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            check("en_hold_busy",  32'(busy),  32'd0);
            check("en_hold_grant", 32'(grant), 32'd0);
        end
        enable = 1'b1;
        step();
        check("en_regrant", 32'(grant), 32'b0100);
        check("en_rebusy",  32'(busy),  32'd1);
        req = 4'b0000;
        repeat (7) step();
        check("en_ack2", 32'(ack), 32'b0100);
        step();

        // Asynchronous reset during OFF, then arbitration restarts at index 0
        req  = 4'b0011;
        code = 12'b000_000_010_010;
        step();
        check("ar_grant0", 32'(grant), 32'b0001);
        repeat (3) step();
        check("ar_off_led",   32'(led_out), 32'd0);
        check("ar_off_busy",  32'(busy),    32'd1);
        check("ar_off_grant", 32'(grant),   32'b0001);
        #2;
        rst = 1'b1;
        #1;
        check("ar_led",   32'(led_out), 32'd0);
        check("ar_busy",  32'(busy),    32'd0);
        check("ar_grant", 32'(grant),   32'd0);
        check("ar_ack",   32'(ack),     32'd0);
        @(negedge clk);
        check("ar_ack_hold", 32'(ack), 32'd0);
        step();
        check("ar_ack_hold2", 32'(ack), 32'd0);
        rst = 1'b0;
        step();
        check("ar_first_grant", 32'(grant),   32'b0001);
        check("ar_first_led",   32'(led_out), 32'd1);
        check("ar_first_busy",  32'(busy),    32'd1);
        req = 4'b0000;
        repeat (14) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
